// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding and
// the all-ones source used for the count wrap compare.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Default geometry of the sequenced counter.
    localparam int unsigned DEF_WIDTH = 2;
    localparam int unsigned DEF_RUN_W = 4;

    // Sliced down to WIDTH bits to form the all-ones count value.
    localparam logic [31:0] ALL_ONES = '1;

endpackage

// File: rtl/jk_count_core.sv
// WIDTH-bit up counter built from JK flops with a toggle chain (J=K=T).
// Ports: clk, rst (async, active-high), en (count), clr (sync, wins), q.
module jk_count_core
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] t;

    // Bit i toggles when enabled and every lower bit is one.
    always_comb begin
        t    = '0;
        t[0] = en;
        for (int i = 1; i < WIDTH; i++) begin
            t[i] = t[i-1] & q_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                // JK characteristic equation with J = K = t[i].
                q_q[i] <= (t[i] & ~q_q[i]) | (~t[i] & q_q[i]);
            end
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_sequencer.sv
// Start/busy/done sequencer running a JK toggle counter for run_len steps.
// Ports: clk, rst, start, run_len, clr, [pause], count, busy, done, wrap.
// Optional pause input when COUNTER_SEQ_PAUSE_EN is defined.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned RUN_W = DEF_RUN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [RUN_W-1:0] run_len,
    input  logic             clr,
`ifdef COUNTER_SEQ_PAUSE_EN
    input  logic             pause,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX = ALL_ONES[WIDTH-1:0];

    state_t           state_q;
    logic [RUN_W-1:0] remaining_q;
    logic             busy_q;
    logic             done_q;
    logic             wrap_q;
    logic             stall;
    logic             cnt_en;
    logic             cnt_clr;

`ifdef COUNTER_SEQ_PAUSE_EN
    assign stall = pause;
`else
    assign stall = 1'b0;
`endif

    assign cnt_en  = (state_q == ST_RUN) & ~stall;
    // clr and increments never overlap: clr only in IDLE, counting only in RUN.
    assign cnt_clr = (state_q == ST_IDLE) & clr;

    jk_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .clr (cnt_clr),
        .q   (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            wrap_q <= cnt_en & (count == CNT_MAX);
            unique case (state_q)
                ST_IDLE: begin
                    if (start && (run_len != '0)) begin
                        state_q     <= ST_RUN;
                        remaining_q <= run_len;
                        busy_q      <= 1'b1;
                    end else if (start) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!stall) begin
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == RUN_W'(1)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    remaining_q <= '0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer (WIDTH=2, RUN_W=4).
// Define COUNTER_SEQ_PAUSE_EN to also exercise the pause input.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] run_len;
    logic       clr;
`ifdef COUNTER_SEQ_PAUSE_EN
    logic       pause;
`endif
    logic [1:0] count;
    logic       busy;
    logic       done;
    logic       wrap;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    counter_sequencer #(
        .WIDTH (2),
        .RUN_W (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .run_len (run_len),
        .clr     (clr),
`ifdef COUNTER_SEQ_PAUSE_EN
        .pause   (pause),
`endif
        .count   (count),
        .busy    (busy),
        .done    (done),
        .wrap    (wrap)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int c, input int b,
                        input int d, input int w);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".wrap"}, 32'(wrap), 32'(w));
    endtask

    initial begin
        bit saw_done;
        int bcyc;
        int nwrap;
        int guard;

        rst     = 1'b1;
        start   = 1'b0;
        run_len = '0;
        clr     = 1'b0;
`ifdef COUNTER_SEQ_PAUSE_EN
        pause   = 1'b0;
`endif
        #3;
        outs("reset", 0, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        outs("idle", 0, 0, 0, 0);

        // 1: basic run of 3
        start = 1'b1; run_len = 4'd3;
        step();
        start = 1'b0;
        outs("t1.accept", 0, 1, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            step();
            outs($sformatf("t1.c%0d", i), i, (i < 3), (i == 3), 0);
        end
        step();
        outs("t1.hold", 3, 0, 0, 0);

        // 2: wrap run of 5 starting from 0
        clr = 1'b1;
        step();
        clr = 1'b0;
        step();
        outs("t2.clr", 0, 0, 0, 0);
        start = 1'b1; run_len = 4'd5;
        step();
        start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            outs($sformatf("t2.c%0d", i), i % 4, (i < 5), (i == 5), (i == 4));
        end
        step();
        outs("t2.hold", 1, 0, 0, 0);

        // 3: zero-length run
        start = 1'b1; run_len = 4'd0;
        step();
        start = 1'b0;
        outs("t3.done", 1, 0, 1, 0);
        step();
        outs("t3.idle", 1, 0, 0, 0);

        // 4: start and clr held during RUN/DONE are ignored
        start = 1'b1; run_len = 4'd2;
        step();
        outs("t4.accept", 1, 1, 0, 0);
        step();
        outs("t4.c2", 2, 1, 0, 0);
        clr = 1'b1;
        step();
        outs("t4.c3", 3, 0, 1, 0);
        step();
        start = 1'b0; clr = 1'b0;
        outs("t4.back", 3, 0, 0, 0);
        step();
        outs("t4.norerun", 3, 0, 0, 0);
        start = 1'b1; run_len = 4'd3;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        outs("t4.to2", 2, 0, 1, 0);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        outs("t4.clr", 0, 0, 0, 0);
        step();
        outs("t4.clrnowrap", 0, 0, 0, 0);

        // 5: asynchronous reset in the middle of a run
        start = 1'b1; run_len = 4'd6;
        step();
        start = 1'b0;
        step();
        step();
        outs("t5.mid", 2, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        outs("t5.async", 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("t5.nodone", 32'(saw_done), 32'd0);
        outs("t5.after", 0, 0, 0, 0);

`ifdef COUNTER_SEQ_PAUSE_EN
        // 6: pause two cycles mid-run
        start = 1'b1; run_len = 4'd4;
        step();
        start = 1'b0;
        bcyc  = 1;
        nwrap = 0;
        guard = 0;
        step();
        bcyc += busy;
        pause = 1'b1;
        step();
        bcyc += busy;
        check("t6.frozen", 32'(count), 32'd1);
        step();
        bcyc += busy;
        pause = 1'b0;
        while (!done && guard < 20) begin
            step();
            bcyc  += busy;
            nwrap += wrap;
            guard++;
        end
        check("t6.timeout", 32'(guard < 20), 32'd1);
        check("t6.busy", 32'(bcyc), 32'd6);
        check("t6.count", 32'(count), 32'd0);
        check("t6.wraps", 32'(nwrap), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
